// File: rtl/qea_host_seq.sv
// Host-side sequencer for the quantum emulation accelerator (QEA).
// It accepts a job command and loads the gate context stream into the context
// RAM. It then initialises the state vector to |0>, starts the QEA and times
// the run. When the run ends it streams the final state vector out.
module qea_host_seq #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_cmd_valid,
  output logic                                 o_cmd_ready,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_cmd_qbit_num,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_cmd_ins_num,
  input  logic                                 s_ctx_valid,
  output logic                                 s_ctx_ready,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   s_ctx_data,
  output logic                                 o_qea_start,
  output logic [MAX_QBIT_WIDTH-1:0]            o_qea_qbit_num,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
  output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
  output logic                                 o_state_ena,
  output logic                                 o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  input  logic                                 i_qea_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_qea_state_dout,
  output logic                                 m_state_valid,
  input  logic                                 m_state_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_state_data,
  output logic                                 m_state_last,
  output logic                                 o_busy,
  output logic                                 o_err,
  output logic [31:0]                          o_exec_cycles
);

  localparam int LANE_W = PE_NUM * STATE_DATA_WIDTH;

  // The smallest job gives each PE two amplitudes. The largest job fills the state RAM.
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH + 1);
  localparam logic [MAX_QBIT_WIDTH-1:0] QBIT_MAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);

  // Amplitude 1.0 of |0> sits in the real part of the top lane of word 0.
  localparam logic [DATA_WIDTH-1:0] FP_ONE    = DATA_WIDTH'(1) << NUM_FRAC_BIT;
  localparam logic [LANE_W-1:0]     INIT_WORD = {FP_ONE, {(LANE_W-DATA_WIDTH){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD_CTX, INIT_STATE, START, RUN, READ} state_t;

  state_t                              state, state_next;
  logic [MAX_QBIT_WIDTH-1:0]           qbit_q;
  logic [MAX_QBIT_WIDTH-1:0]           addr_bits;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ins_last_q;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]  ctx_addr_q;
  logic [STATE_ADDR_WIDTH-1:0]         init_addr_q;
  logic [STATE_ADDR_WIDTH-1:0]         rd_addr_q;
  logic [STATE_ADDR_WIDTH-1:0]         n_last;
  logic                                err_q;
  logic [31:0]                         exec_q;
  logic [1:0]                          run_cnt_q;
  logic                                rd_pending_q;
  logic                                rd_last_q;
  logic                                rd_done_q;
  logic                                out_valid_q;
  logic                                out_last_q;
  logic [LANE_W-1:0]                   out_data_q;
  logic                                cmd_good;
  logic                                ctx_fire;
  logic                                rd_issue;
  logic                                out_fire;

  assign cmd_good = (i_cmd_qbit_num >= QBIT_MIN) && (i_cmd_qbit_num <= QBIT_MAX) &&
                    (i_cmd_ins_num != '0);

  // The state vector is 2^(qbit-PE_NUM_WIDTH) words deep. n_last is its last address.
  assign addr_bits = qbit_q - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  assign n_last    = ~({STATE_ADDR_WIDTH{1'b1}} << addr_bits);

  assign o_qea_qbit_num = qbit_q;
  assign o_busy         = (state != IDLE);
  assign o_err          = err_q;
  assign o_exec_cycles  = exec_q;
  assign m_state_valid  = out_valid_q;
  assign m_state_last   = out_last_q;
  assign m_state_data   = out_data_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and RAM/stream strobes. A cycle with reset asserted issues no RAM access.
  always_comb begin
    state_next    = state;
    o_cmd_ready   = 1'b0;
    s_ctx_ready   = 1'b0;
    o_ctx_en      = 1'b0;
    o_ctx_wea     = 1'b0;
    o_ctx_addr    = '0;
    o_ctx_data    = '0;
    o_qea_start   = 1'b0;
    o_state_ena   = 1'b0;
    o_state_wea   = 1'b0;
    o_state_addra = '0;
    o_state_dina  = '0;
    ctx_fire      = 1'b0;
    rd_issue      = 1'b0;
    out_fire      = 1'b0;
    case (state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid && cmd_good) state_next = LOAD_CTX;
      end
      LOAD_CTX: begin
        s_ctx_ready = 1'b1;
        ctx_fire    = s_ctx_valid;
        if (ctx_fire) begin
          o_ctx_en   = 1'b1;
          o_ctx_wea  = 1'b1;
          o_ctx_addr = ctx_addr_q;
          o_ctx_data = s_ctx_data;
          if (ctx_addr_q == ins_last_q) state_next = INIT_STATE;
        end
      end
      INIT_STATE: begin
        o_state_ena   = 1'b1;
        o_state_wea   = 1'b1;
        o_state_addra = init_addr_q;
        o_state_dina  = (init_addr_q == '0) ? INIT_WORD : '0;
        if (init_addr_q == n_last) state_next = START;
      end
      START: begin
        o_qea_start = 1'b1;
        state_next  = RUN;
      end
      RUN: begin
        if ((run_cnt_q == 2'd2) && i_qea_complete) state_next = READ;
      end
      READ: begin
        out_fire = out_valid_q && m_state_ready;
        rd_issue = !out_valid_q && !rd_pending_q && !rd_done_q;
        if (rd_issue) begin
          o_state_ena   = 1'b1;
          o_state_addra = rd_addr_q;
        end
        if (out_fire && out_last_q) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (!rst_n) begin
      state_next    = IDLE;
      s_ctx_ready   = 1'b0;
      o_ctx_en      = 1'b0;
      o_ctx_wea     = 1'b0;
      o_ctx_addr    = '0;
      o_ctx_data    = '0;
      o_qea_start   = 1'b0;
      o_state_ena   = 1'b0;
      o_state_wea   = 1'b0;
      o_state_addra = '0;
      o_state_dina  = '0;
      ctx_fire      = 1'b0;
      rd_issue      = 1'b0;
      out_fire      = 1'b0;
    end
  end

  // Job datapath: command latch, address counters, run timer and the one-deep read pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qbit_q       <= '0;
      ins_last_q   <= '0;
      ctx_addr_q   <= '0;
      init_addr_q  <= '0;
      rd_addr_q    <= '0;
      err_q        <= 1'b0;
      exec_q       <= '0;
      run_cnt_q    <= '0;
      rd_pending_q <= 1'b0;
      rd_last_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_cmd_valid) begin
            if (cmd_good) begin
              qbit_q       <= i_cmd_qbit_num;
              ins_last_q   <= i_cmd_ins_num - GATE_CONTEXT_ADDR_WIDTH'(1);
              err_q        <= 1'b0;
              ctx_addr_q   <= '0;
              init_addr_q  <= '0;
              rd_addr_q    <= '0;
              rd_pending_q <= 1'b0;
              rd_last_q    <= 1'b0;
              rd_done_q    <= 1'b0;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        LOAD_CTX: begin
          if (ctx_fire) ctx_addr_q <= ctx_addr_q + GATE_CONTEXT_ADDR_WIDTH'(1);
        end
        INIT_STATE: begin
          init_addr_q <= init_addr_q + STATE_ADDR_WIDTH'(1);
        end
        START: begin
          exec_q    <= 32'd1;
          run_cnt_q <= 2'd0;
        end
        RUN: begin
          if (exec_q != 32'hFFFF_FFFF) exec_q <= exec_q + 32'd1;
          if (run_cnt_q != 2'd2) run_cnt_q <= run_cnt_q + 2'd1;
        end
        READ: begin
          if (rd_issue) begin
            rd_pending_q <= 1'b1;
            rd_addr_q    <= rd_addr_q + STATE_ADDR_WIDTH'(1);
            rd_last_q    <= (rd_addr_q == n_last);
            if (rd_addr_q == n_last) rd_done_q <= 1'b1;
          end
          if (rd_pending_q) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= i_qea_state_dout;
            out_last_q   <= rd_last_q;
            rd_pending_q <= 1'b0;
          end
          if (out_fire) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qea_host_seq.sv
// Directed bench for qea_host_seq. It uses scoreboard queues for the ctx writes,
// the state writes and the result stream, and a one-cycle-latency state RAM model.
module tb_qea_host_seq;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_cmd_valid = 1'b0;
  logic           o_cmd_ready;
  logic [5:0]     i_cmd_qbit_num = '0;
  logic [15:0]    i_cmd_ins_num = '0;
  logic           s_ctx_valid = 1'b0;
  logic           s_ctx_ready;
  logic [63:0]    s_ctx_data = '0;
  logic           o_qea_start;
  logic [5:0]     o_qea_qbit_num;
  logic           o_ctx_en, o_ctx_wea;
  logic [15:0]    o_ctx_addr;
  logic [63:0]    o_ctx_data;
  logic           o_state_ena, o_state_wea;
  logic [15:0]    o_state_addra;
  logic [255:0]   o_state_dina;
  logic           i_qea_complete = 1'b0;
  logic [255:0]   i_qea_state_dout = '0;
  logic           m_state_valid;
  logic           m_state_ready = 1'b1;
  logic [255:0]   m_state_data;
  logic           m_state_last;
  logic           o_busy, o_err;
  logic [31:0]    o_exec_cycles;

  int             checks = 0;
  int             failures = 0;
  logic [80:0]    ctx_q[$];
  logic [272:0]   st_q[$];
  logic [256:0]   out_q[$];
  int             ctx_wr_cnt = 0, st_wr_cnt = 0, start_cnt = 0, out_cnt = 0, last_cnt = 0;
  logic           rand_ready = 1'b0;
  logic [31:0]    salt = '0;
  logic           prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
  logic [255:0]   prev_d = '0;

  always #5 clk = ~clk;

  qea_host_seq dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_qbit_num(i_cmd_qbit_num), .i_cmd_ins_num(i_cmd_ins_num),
    .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
    .o_qea_start(o_qea_start), .o_qea_qbit_num(o_qea_qbit_num),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina),
    .i_qea_complete(i_qea_complete), .i_qea_state_dout(i_qea_state_dout),
    .m_state_valid(m_state_valid), .m_state_ready(m_state_ready),
    .m_state_data(m_state_data), .m_state_last(m_state_last),
    .o_busy(o_busy), .o_err(o_err), .o_exec_cycles(o_exec_cycles)
  );

  function automatic logic [255:0] ram_word(input logic [15:0] a);
    return {salt ^ {16'h0, a}, {a, 16'hBEEF}, ~salt, {16'h0, a},
            salt + {16'h0, a}, 32'h0F0F_0000 ^ {a, a}, {a, ~a}, salt ^ 32'hFFFF_0000};
  endfunction

  task automatic check_output(input string tag, input logic [279:0] obs, input logic [279:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitors: scoreboard pops, event counts, stall stability and reset-cycle quietness.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
      check_output("no_ram_access_in_reset", {o_ctx_en, o_state_ena, o_qea_start, s_ctx_ready}, 0);
    end else begin
      if (o_ctx_en) begin
        ctx_wr_cnt++;
        check_output("ctx_q_avail", ctx_q.size() != 0, 1);
        if (ctx_q.size() != 0) check_output("ctx_write", {o_ctx_wea, o_ctx_addr, o_ctx_data}, ctx_q.pop_front());
      end
      if (o_state_ena && o_state_wea) begin
        st_wr_cnt++;
        check_output("st_q_avail", st_q.size() != 0, 1);
        if (st_q.size() != 0) check_output("state_write", {o_state_wea, o_state_addra, o_state_dina}, st_q.pop_front());
      end
      if (o_qea_start) start_cnt++;
      if (prev_v && !prev_r) begin
        check_output("stall_valid", m_state_valid, 1);
        check_output("stall_data", {m_state_last, m_state_data}, {prev_l, prev_d});
      end
      if (m_state_valid && m_state_ready) begin
        out_cnt++;
        if (m_state_last) last_cnt++;
        check_output("out_q_avail", out_q.size() != 0, 1);
        if (out_q.size() != 0) check_output("out_word", {m_state_last, m_state_data}, out_q.pop_front());
      end
      prev_v = m_state_valid;
      prev_r = m_state_ready;
      prev_l = m_state_last;
      prev_d = m_state_data;
    end
  end

  // State RAM read model with one cycle of latency.
  initial begin
    logic        rd;
    logic [15:0] a;
    forever begin
      @(negedge clk);
      rd = rst_n && o_state_ena && !o_state_wea;
      a  = o_state_addra;
      @(posedge clk);
      #1;
      if (rd) i_qea_state_dout = ram_word(a);
    end
  end

  // Result stream consumer, either always ready or randomly back-pressured.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_state_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_reset_state();
    check_output("rst_flags", {o_ctx_en, o_ctx_wea, o_state_ena, o_state_wea, o_qea_start,
                               m_state_valid, m_state_last, o_busy, o_err, s_ctx_ready}, 0);
    check_output("rst_exec", o_exec_cycles, 0);
    check_output("rst_addr", {o_ctx_addr, o_state_addra}, 0);
    check_output("rst_ctx_data", o_ctx_data, 0);
    check_output("rst_state_dina", o_state_dina, 0);
    check_output("rst_m_data", m_state_data, 0);
    check_output("rst_cmd_ready", o_cmd_ready, 1);
  endtask

  task automatic do_reset(input bit poke_ctx);
    rst_n = 1'b0;
    i_qea_complete = 1'b0;
    rand_ready = 1'b0;
    if (poke_ctx) begin
      s_ctx_valid = 1'b1;
      s_ctx_data  = 64'hDEAD_BEEF_0BAD_F00D;
    end
    ctx_q.delete();
    st_q.delete();
    out_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_ctx_valid = 1'b0;
    s_ctx_data  = '0;
    check_reset_state();
  endtask

  task automatic apply_cmd(input int qbit, input int ins);
    i_cmd_valid    = 1'b1;
    i_cmd_qbit_num = 6'(qbit);
    i_cmd_ins_num  = 16'(ins);
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic bad_cmd(input string tag, input int qbit, input int ins);
    ctx_wr_cnt = 0; st_wr_cnt = 0; start_cnt = 0;
    apply_cmd(qbit, ins);
    repeat (2) @(posedge clk);
    #1;
    check_output({tag, "_err"}, o_err, 1);
    check_output({tag, "_busy"}, o_busy, 0);
    check_output({tag, "_no_ram"}, {ctx_wr_cnt[15:0], st_wr_cnt[15:0], start_cnt[15:0]}, 0);
  endtask

  // abort: 0 = run to completion, 1 = reset during RUN, 2 = reset during READ.
  task automatic run_job(input int qbit, input int ins, input bit toggle, input bit rnd,
                         input int delay, input int abort);
    int n;
    bit got;
    int exp_exec;
    n = 1 << (qbit - 2);
    exp_exec = (delay < 3) ? 4 : delay + 1;
    rand_ready = rnd;
    salt = $urandom;
    ctx_wr_cnt = 0; st_wr_cnt = 0; start_cnt = 0; out_cnt = 0; last_cnt = 0;
    for (int j = 0; j < n; j++) begin
      st_q.push_back({1'b1, 16'(j), (j == 0) ? {32'h4000_0000, 224'h0} : 256'h0});
      out_q.push_back({(j == n - 1), ram_word(16'(j))});
    end
    apply_cmd(qbit, ins);
    check_output("cmd_err_cleared", o_err, 0);
    check_output("cmd_busy", {o_busy, o_cmd_ready}, 2'b10);
    for (int k = 0; k < ins; k++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      s_ctx_data  = d;
      s_ctx_valid = 1'b1;
      ctx_q.push_back({1'b1, 16'(k), d});
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        @(negedge clk);
        got = s_ctx_ready;
        @(posedge clk);
        #1;
      end
      check_output("ctx_handshake", got, 1);
      s_ctx_valid = 1'b0;
      s_ctx_data  = '0;
      if (toggle) begin
        @(posedge clk);
        #1;
      end
    end
    got = 1'b0;
    for (int t = 0; t < n + 20 && !got; t++) begin
      @(negedge clk);
      got = o_qea_start;
    end
    check_output("start_seen", got, 1);
    if (abort == 1) begin
      repeat (10) @(posedge clk);
      #1;
      do_reset(1'b0);
      return;
    end
    if (delay >= 10) begin
      repeat (5) @(posedge clk);
      #1;
      i_cmd_valid = 1'b1; i_cmd_qbit_num = 6'd2; i_cmd_ins_num = 16'd0;
      @(posedge clk);
      #1;
      i_cmd_valid = 1'b0;
      check_output("cmd_ignored_busy", {o_err, o_busy}, 2'b01);
      repeat (delay - 6) @(posedge clk);
    end else begin
      repeat (delay) @(posedge clk);
    end
    #1;
    i_qea_complete = 1'b1;
    if (abort == 2) begin
      got = 1'b0;
      for (int t = 0; t < 200 && !got; t++) begin
        @(negedge clk);
        got = m_state_valid;
      end
      check_output("read_reached", got, 1);
      @(posedge clk);
      #1;
      do_reset(1'b0);
      return;
    end
    got = 1'b0;
    for (int t = 0; t < n * 30 + 300 && !got; t++) begin
      @(negedge clk);
      got = !o_busy;
    end
    check_output("job_done", got, 1);
    check_output("ctx_write_count", ctx_wr_cnt, ins);
    check_output("state_write_count", st_wr_cnt, n);
    check_output("start_pulse_count", start_cnt, 1);
    check_output("out_word_count", out_cnt, n);
    check_output("last_count", last_cnt, 1);
    check_output("queues_drained", {ctx_q.size(), st_q.size(), out_q.size()}, 0);
    check_output("exec_cycles", o_exec_cycles, exp_exec);
    check_output("qbit_latched", o_qea_qbit_num, qbit);
    i_qea_complete = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    $display("[TB] qea_host_seq bench start");
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_reset_state();

    bad_cmd("bad_qbit2", 2, 5);
    bad_cmd("bad_qbit19", 19, 5);
    bad_cmd("bad_ins0", 4, 0);

    run_job(4, 5, 1'b0, 1'b0, 100, 0);
    run_job(5, 7, 1'b1, 1'b1, 0, 0);
    run_job(4, 3, 1'b0, 1'b0, 20, 1);
    run_job(4, 2, 1'b1, 1'b1, 5, 2);
    run_job(3, 1, 1'b0, 1'b1, 5, 0);

    ctx_wr_cnt = 0;
    apply_cmd(18, 4);
    check_output("qbit18_accepted", {o_busy, o_err}, 2'b10);
    do_reset(1'b1);
    check_output("qbit18_no_ctx_write", ctx_wr_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
